// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: rotates a Q2.14 vector by a Q2.14 angle,
// one micro-rotation per cycle, followed by a single gain-compensation cycle.
module cordic_rotation (
  input  logic               Clk,
  input  logic               Rst,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  input  logic signed [15:0] theta_in,
  input  logic               operands_val,
  input  logic               ack,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out,
  output logic               out_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ITER  = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // 1/K in Q2.14
  localparam logic signed [33:0] GAIN = 34'sd9949;

  logic [1:0]         state;
  logic [3:0]         iter;
  logic signed [17:0] x_acc, y_acc, z_acc;
  logic signed [17:0] x_sh, y_sh, atan_i;
  logic signed [17:0] x_next, y_next, z_next;
  logic signed [33:0] x_wide, y_wide, x_prod, y_prod;

  function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
    logic signed [17:0] a;
    case (idx)
      4'd0:    a = 18'sh03244;
      4'd1:    a = 18'sh01DAC;
      4'd2:    a = 18'sh00FAE;
      4'd3:    a = 18'sh007F5;
      4'd4:    a = 18'sh003FF;
      4'd5:    a = 18'sh00200;
      4'd6:    a = 18'sh00100;
      4'd7:    a = 18'sh00080;
      4'd8:    a = 18'sh00040;
      4'd9:    a = 18'sh00020;
      4'd10:   a = 18'sh00010;
      4'd11:   a = 18'sh00008;
      4'd12:   a = 18'sh00004;
      4'd13:   a = 18'sh00002;
      4'd14:   a = 18'sh00001;
      default: a = 18'sh00000;
    endcase
    return a;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    logic signed [15:0] r;
    if (v > 34'sd32767)
      r = 16'sh7FFF;
    else if (v < -34'sd32768)
      r = 16'sh8000;
    else
      r = v[15:0];
    return r;
  endfunction

  // micro-rotation datapath; direction follows the sign of the residual angle
  always_comb begin
    x_sh   = x_acc >>> iter;
    y_sh   = y_acc >>> iter;
    atan_i = atan_lut(iter);
    if (z_acc[17]) begin
      x_next = x_acc + y_sh;
      y_next = y_acc - x_sh;
      z_next = z_acc + atan_i;
    end else begin
      x_next = x_acc - y_sh;
      y_next = y_acc + x_sh;
      z_next = z_acc - atan_i;
    end
  end

  // gain compensation; arithmetic shift of the full product floors toward -inf
  always_comb begin
    x_wide = {{16{x_acc[17]}}, x_acc};
    y_wide = {{16{y_acc[17]}}, y_acc};
    x_prod = x_wide * GAIN;
    y_prod = y_wide * GAIN;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      iter      <= 4'd0;
      x_acc     <= '0;
      y_acc     <= '0;
      z_acc     <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (operands_val) begin
            x_acc <= {{2{x_in[15]}}, x_in};
            y_acc <= {{2{y_in[15]}}, y_in};
            z_acc <= {{2{theta_in[15]}}, theta_in};
            iter  <= 4'd0;
            state <= ITER;
          end
        end
        ITER: begin
          x_acc <= x_next;
          y_acc <= y_next;
          z_acc <= z_next;
          iter  <= iter + 4'd1;
          if (iter == 4'd15)
            state <= SCALE;
        end
        SCALE: begin
          x_out     <= sat16(x_prod >>> 14);
          y_out     <= sat16(y_prod >>> 14);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (ack) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotation.sv
// Directed bench for cordic_rotation: angle vectors, handshake, reset and round trip.
module tb_cordic_rotation;

  logic               Clk = 1'b0;
  logic               Rst;
  logic signed [15:0] x_in, y_in, theta_in;
  logic               operands_val, ack;
  logic signed [15:0] x_out, y_out;
  logic               out_valid;

  int errors = 0;
  int checks = 0;

  cordic_rotation dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .x_in         (x_in),
    .y_in         (y_in),
    .theta_in     (theta_in),
    .operands_val (operands_val),
    .ack          (ack),
    .x_out        (x_out),
    .y_out        (y_out),
    .out_valid    (out_valid)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic start(input logic [15:0] x, input logic [15:0] y, input logic [15:0] th);
    @(negedge Clk);
    x_in = x; y_in = y; theta_in = th;
    operands_val = 1'b1;
    @(posedge Clk); #1;
    operands_val = 1'b0;
    x_in = 16'h7777; y_in = 16'h1234; theta_in = 16'h5555;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask

  task automatic give_ack();
    @(negedge Clk);
    ack = 1'b1;
    @(posedge Clk); #1;
    ack = 1'b0;
    check("ack_drops_valid", int'(out_valid), 0, 0);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] th, input int ex, input int ey, input int tol);
    int n;
    start(x, y, th);
    wait_valid(n);
    check({tag, "_latency"}, n, 17, 0);
    check({tag, "_x"}, int'(x_out), ex, tol);
    check({tag, "_y"}, int'(y_out), ey, tol);
  endtask

  initial begin
    int n;
    Rst = 1'b1; operands_val = 1'b0; ack = 1'b0;
    x_in = '0; y_in = '0; theta_in = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_valid", int'(out_valid), 0, 0);
    check("rst_x", int'(x_out), 0, 0);
    check("rst_y", int'(y_out), 0, 0);
    @(negedge Clk);
    Rst = 1'b0;

    run_vec("th0", 16'h4000, 16'h0000, 16'h0000, 16384, 0, 4);
    give_ack();

    // pulse operands_val mid-iteration with a different request
    start(16'h4000, 16'h0000, 16'h3244);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    x_in = 16'h1000; theta_in = 16'h6488; operands_val = 1'b1;
    @(posedge Clk); #1;
    operands_val = 1'b0;
    wait_valid(n);
    check("pi4_latency", n, 12, 0);
    check("pi4_x", int'(x_out), 16'h2D41, 4);
    check("pi4_y", int'(y_out), 16'h2D41, 4);

    // operands_val in DONE, then ack withheld for 10 cycles
    @(negedge Clk);
    x_in = 16'h1000; theta_in = 16'h0000; operands_val = 1'b1;
    @(posedge Clk); #1;
    operands_val = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", int'(out_valid), 1, 0);
      check("hold_x", int'(x_out), 16'h2D41, 4);
      check("hold_y", int'(y_out), 16'h2D41, 4);
      @(posedge Clk); #1;
    end
    give_ack();

    // back-to-back request on the cycle after ack
    run_vec("pi2", 16'h4000, 16'h0000, 16'h6488, 0, 16384, 4);
    give_ack();
    repeat (20) @(posedge Clk);
    #1;
    check("idle_no_restart", int'(out_valid), 0, 0);

    // reset mid-iteration discards the operation
    run_vec("m30", 16'h4000, 16'h0000, 16'hDE7D, 16'h376D, -8192, 4);
    give_ack();
    start(16'h4000, 16'h0000, 16'h3244);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("midrst_valid", int'(out_valid), 0, 0);
    check("midrst_x", int'(x_out), 0, 0);
    check("midrst_y", int'(y_out), 0, 0);
    repeat (20) @(posedge Clk);
    #1;
    check("midrst_discard", int'(out_valid), 0, 0);
    run_vec("after_rst", 16'h4000, 16'h0000, 16'hDE7D, 16'h376D, -8192, 4);
    give_ack();

    // reset wins over a simultaneous request
    @(negedge Clk);
    Rst = 1'b1; operands_val = 1'b1; theta_in = 16'h0000; x_in = 16'h4000;
    @(posedge Clk); #1;
    Rst = 1'b0; operands_val = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    check("rst_beats_load", int'(out_valid), 0, 0);

    // round trip: magnitude 14768 and angle atan(2/3) for (0x3000, 0x2000)
    run_vec("round", 16'h39B0, 16'h0000, 16'h25A2, 16'h3000, 16'h2000, 8);
    give_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
